// File: rtl/proto_tree_walker_if.sv
// Port bundle for proto_tree_walker: node-table config, parser events in,
// message-hierarchy state and start/end events out.
interface proto_tree_walker_if #(
  parameter int ID_W      = 5,
  parameter int NUM_NODES = 8,
  parameter int MAX_DEPTH = 4,
  parameter int LEN_W     = 16,
  parameter int NODE_W    = $clog2(NUM_NODES)
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic                 cfg_we;
  logic [NODE_W-1:0]    cfg_addr;
  logic                 cfg_valid;
  logic [NODE_W-1:0]    cfg_parent;
  logic [ID_W-1:0]      cfg_field_id;
  logic                 flush;
  logic                 byte_en;
  logic                 tag_valid;
  logic [ID_W-1:0]      tag_id;
  logic [LEN_W-1:0]     tag_len;
  logic [NODE_W-1:0]    cur_node;
  logic [DEPTH_W-1:0]   cur_depth;
  logic                 msg_start;
  logic [NODE_W-1:0]    start_node;
  logic                 msg_end;
  logic [MAX_DEPTH-1:0] end_mask;
  logic                 err_depth;
  logic                 err_overrun;
  logic                 err_cfg;

  modport master (
    output cfg_we, cfg_addr, cfg_valid, cfg_parent, cfg_field_id,
    output flush, byte_en, tag_valid, tag_id, tag_len,
    input  cur_node, cur_depth, msg_start, start_node, msg_end, end_mask,
    input  err_depth, err_overrun, err_cfg
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_valid, cfg_parent, cfg_field_id,
    input  flush, byte_en, tag_valid, tag_id, tag_len,
    output cur_node, cur_depth, msg_start, start_node, msg_end, end_mask,
    output err_depth, err_overrun, err_cfg
  );
endinterface

// File: rtl/proto_tree_walker.sv
// Tracks protobuf submessage nesting: matches length-delimited tags against a
// programmable node table and pops levels as their payload bytes are consumed.
module proto_tree_walker #(
  parameter int ID_W      = 5,
  parameter int NUM_NODES = 8,
  parameter int MAX_DEPTH = 4,
  parameter int LEN_W     = 16,
  parameter int NODE_W    = $clog2(NUM_NODES)
) (
  input  logic               clk,
  input  logic               rst_n,
  proto_tree_walker_if.slave bus
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  // Entry 0 is the implicit root and has no storage.
  logic                tbl_valid  [1:NUM_NODES-1];
  logic [NODE_W-1:0]   tbl_parent [1:NUM_NODES-1];
  logic [ID_W-1:0]     tbl_id     [1:NUM_NODES-1];
  logic [NODE_W-1:0]   stk_node   [MAX_DEPTH];
  logic [LEN_W-1:0]    stk_rem    [MAX_DEPTH];
  logic [DEPTH_W-1:0]  depth;

  logic                byte_act, tag_act;
  logic [LEN_W-1:0]    rem_dec [MAX_DEPTH];
  logic [DEPTH_W-1:0]  depth_pop, depth_nxt;
  logic [MAX_DEPTH-1:0] pop_mask;
  logic [NODE_W-1:0]   top_node, hit_node, node_nxt;
  logic [LEN_W-1:0]    top_rem;
  logic                hit, tag_hit, zero_len, depth_full, overrun, do_push, cfg_ok, cfg_bad;

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    byte_act = bus.byte_en && !bus.flush;
    tag_act  = bus.tag_valid && !bus.flush;

    for (int k = 0; k < MAX_DEPTH; k++) begin
      rem_dec[k] = stk_rem[k];
      if (byte_act && DEPTH_W'(k) < depth) rem_dec[k] = stk_rem[k] - 1'b1;
    end

    // Child remaining never exceeds parent, so the exhausted levels are a
    // contiguous run at the top; find its lowest member.
    depth_pop = depth;
    for (int k = MAX_DEPTH - 1; k >= 0; k--)
      if (DEPTH_W'(k) < depth && rem_dec[k] == '0) depth_pop = DEPTH_W'(k);

    pop_mask = '0;
    top_node = '0;
    top_rem  = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DEPTH_W'(k) >= depth_pop && DEPTH_W'(k) < depth) pop_mask[k] = 1'b1;
      if (DEPTH_W'(k + 1) == depth_pop) begin
        top_node = stk_node[k];
        top_rem  = rem_dec[k];
      end
    end

    hit      = 1'b0;
    hit_node = '0;
    for (int i = NUM_NODES - 1; i >= 1; i--)
      if (tbl_valid[i] && tbl_parent[i] == top_node && tbl_id[i] == bus.tag_id) begin
        hit      = 1'b1;
        hit_node = NODE_W'(i);
      end

    tag_hit    = tag_act && hit;
    zero_len   = tag_hit && bus.tag_len == '0;
    depth_full = tag_hit && !zero_len && depth_pop == DEPTH_W'(MAX_DEPTH);
    overrun    = tag_hit && !zero_len && !depth_full && depth_pop != '0 && bus.tag_len > top_rem;
    do_push    = tag_hit && !zero_len && !depth_full && !overrun;
    depth_nxt  = do_push ? depth_pop + 1'b1 : depth_pop;
    node_nxt   = do_push ? hit_node : top_node;

    cfg_ok  = bus.cfg_we && bus.cfg_addr != '0 && depth == '0 && !do_push;
    cfg_bad = bus.cfg_we && bus.cfg_addr != '0 && !cfg_ok;
  end

  assign bus.cur_depth = depth;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth           <= '0;
      bus.cur_node    <= '0;
      bus.msg_start   <= 1'b0;
      bus.start_node  <= '0;
      bus.msg_end     <= 1'b0;
      bus.end_mask    <= '0;
      bus.err_depth   <= 1'b0;
      bus.err_overrun <= 1'b0;
      bus.err_cfg     <= 1'b0;
      for (int i = 1; i < NUM_NODES; i++) tbl_valid[i] <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_NODES; i++)
        if (cfg_ok && NODE_W'(i) == bus.cfg_addr) tbl_valid[i] <= bus.cfg_valid;

      if (bus.flush) begin
        depth           <= '0;
        bus.cur_node    <= '0;
        bus.msg_start   <= 1'b0;
        bus.msg_end     <= 1'b0;
        bus.end_mask    <= '0;
        bus.err_depth   <= 1'b0;
        bus.err_overrun <= 1'b0;
        bus.err_cfg     <= 1'b0;
      end else begin
        depth           <= depth_nxt;
        bus.cur_node    <= node_nxt;
        bus.msg_start   <= do_push || zero_len;
        bus.msg_end     <= (|pop_mask) || zero_len;
        bus.end_mask    <= pop_mask;
        if (do_push || zero_len) bus.start_node <= hit_node;
        bus.err_depth   <= bus.err_depth   || depth_full;
        bus.err_overrun <= bus.err_overrun || overrun;
        bus.err_cfg     <= bus.err_cfg     || cfg_bad;
      end
    end
  end

  // NOTE: table payload and stack contents are qualified by valid bits and
  // depth, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_NODES; i++)
      if (cfg_ok && NODE_W'(i) == bus.cfg_addr) begin
        tbl_parent[i] <= bus.cfg_parent;
        tbl_id[i]     <= bus.cfg_field_id;
      end
    for (int k = 0; k < MAX_DEPTH; k++) begin
      stk_rem[k] <= rem_dec[k];
      if (do_push && DEPTH_W'(k) == depth_pop) begin
        stk_node[k] <= hit_node;
        stk_rem[k]  <= bus.tag_len;
      end
    end
  end
endmodule

// File: doc/proto_tree_walker.md
# proto_tree_walker

Streaming message-hierarchy tracker for the protobuf decode path: a parametrised, run-time-programmable successor to the fixed person/phone-number dependency tables. A node table (parent, field id) is loaded through a config port; as the upstream parser reports length-delimited tags and consumed bytes, the block matches tags against children of the current node, maintains a length-tracking nesting stack, and reports the current message node plus message start/end events to downstream field handlers.

## Interface
- `ID_W`, 5: field identifier width.
- `NUM_NODES`, 8: node table entries; entry 0 is the hardwired root (null message).
- `MAX_DEPTH`, 4: nesting stack levels, excluding the root.
- `LEN_W`, 16: length / remaining-byte counter width.
- `NODE_W`, $clog2(NUM_NODES): node index width (derived).
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous active-low reset.
- `cfg_we`  in  1  node table write strobe.
- `cfg_addr`  in  NODE_W  entry to write; 0 ignored.
- `cfg_valid`  in  1  entry valid bit.
- `cfg_parent`  in  NODE_W  parent node index.
- `cfg_field_id`  in  ID_W  field id selecting this node under its parent.
- `flush`  in  1  clear stack, current node and error flags; table kept.
- `byte_en`  in  1  one encoded byte consumed this cycle (headers and payload).
- `tag_valid`  in  1  a length-delimited tag has been fully parsed.
- `tag_id`  in  ID_W  its field id.
- `tag_len`  in  LEN_W  its payload length in bytes.
- `cur_node`  out  NODE_W  current innermost message node.
- `cur_depth`  out  $clog2(MAX_DEPTH+1)  current stack depth.
- `msg_start`  out  1  pulse: a submessage was entered.
- `start_node`  out  NODE_W  node entered, valid with `msg_start`.
- `msg_end`  out  1  pulse: one or more levels closed.
- `end_mask`  out  MAX_DEPTH  bit k set = stack level k (0 = outermost) closed.
- `err_depth`, `err_overrun`, `err_cfg`  out  1 each  sticky error flags.

## Operation
- State: table `{valid, parent, field_id}` x NUM_NODES; stack of MAX_DEPTH entries `{node, remaining}`; depth register.
- Byte accounting: each `byte_en` decrements `remaining` of every occupied level in parallel. A level whose remaining reaches 0 is popped; all levels reaching 0 in the same cycle pop together (child remaining <= parent remaining is guaranteed by the overrun check).
- Tag match: parallel compare over entries 1..NUM_NODES-1 for `valid && parent == node_after_pops && field_id == tag_id`; lowest matching index wins.
- Ordering within a cycle: byte decrement, then pops, then tag match against post-pop top, then push. The byte on a `tag_valid` cycle is never counted against the level being pushed.
- Hit, `tag_len` > 0, depth < MAX_DEPTH, `tag_len` <= post-decrement remaining of post-pop top (root is unbounded): push `{hit, tag_len}`, pulse `msg_start`.
- Hit, `tag_len` == 0: no push; `msg_start` and `msg_end` pulse together, `start_node` = hit, `end_mask` = 0.
- Hit at depth == MAX_DEPTH: set `err_depth`, no push, no `msg_start`.
- Hit, `tag_len` > remaining of top: set `err_overrun`, no push.
- Miss: no action; payload bytes are still counted against open levels.
- Underflow impossible: an empty stack ignores `byte_en`.
- Config: a write applies only when depth == 0 and no tag is being pushed in that cycle; otherwise ignored and `err_cfg` set. A write with `cfg_addr` 0 is ignored without error.
- `flush`: depth 0, `cur_node` 0, errors cleared, pulses suppressed that cycle; it overrides same-cycle `tag_valid` and `byte_en`.
- Reset: all table valid bits 0, stack empty, `cur_node` 0, `cur_depth` 0, `msg_start`/`msg_end` 0, `end_mask` 0, `start_node` 0, all errors 0.

## Timing
- No backpressure; one event per cycle is accepted on every input.
- All outputs are registered. Events in cycle N appear on outputs in cycle N+1: `cur_node`, `cur_depth`, pulses and error flags.
- `msg_start`/`msg_end` are single-cycle pulses and may coincide (pop then push in the same cycle).
- A table write in cycle N is visible to a tag match in cycle N+1.

## Test plan
- Table: node1 = {parent 0, id 1}, node2 = {parent 1, id 4}. Tag id1 len 4 -> msg_start, start_node 1, depth 1. Two header bytes, then tag id4 len 2 -> start_node 2, depth 2. Two bytes -> msg_end, end_mask 0b0011, depth 0, cur_node 0.
- At depth 1 (node1, len 10), tag id 7 len 3 -> no msg_start, cur_node stays 1. After 10 total bytes -> msg_end, end_mask 0b0001.
- MAX_DEPTH=2, node3 = {parent 2, id 1}, nesting 1 -> 4 -> 1 -> err_depth = 1, depth stays 2, cur_node 2.
- Node1 len 4, 2 header bytes, tag id4 len 5 -> err_overrun = 1, no push, depth 1.
- Tag id1 len 0 at root -> msg_start and msg_end in the same cycle, start_node 1, end_mask 0, depth 0.
- cfg_we at depth 1 -> err_cfg = 1, entry unchanged. Drop `rst_n` at depth 2 -> next cycle depth 0, cur_node 0, all errors 0, table invalid, so tag id1 misses.
